// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, widths, FSM state type and bit helpers
package des_pkg;
  localparam int KEY_W = 64;
  localparam int HALF_W = 28;
  localparam int SUBKEY_W = 48;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FINISH} state_t;
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFT [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // DES bit n of the key sits at key[KEY_W+1-n]; CD bit n sits at cd[2*HALF_W-n]
  function automatic logic [2*HALF_W-1:0] pc1(input logic [KEY_W:1] k);
    logic [2*HALF_W-1:0] r;
    for (int i = 0; i < 2 * HALF_W; i++) r[2*HALF_W-1-i] = k[KEY_W+1-PC1[i]];
    return r;
  endfunction
  // left rotation of a 28-bit half; s may range 0..28
  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input int s);
    logic [2*HALF_W-1:0] y;
    y = {x, x} << s;
    return y[2*HALF_W-1:HALF_W];
  endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational PC-2 compression of the 56-bit C||D into a 48-bit subkey
module des_pc2
  import des_pkg::*;
(
  input  logic [2*HALF_W-1:0] cd,
  output logic [SUBKEY_W:1]   subkey
);
  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_bit
    assign subkey[SUBKEY_W-i] = cd[2*HALF_W-PC2[i]];
  end
  // PC-2 drops eight CD bits by definition
  logic unused_cd;
  assign unused_cd = ^cd;
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: streams the 16 DES round keys (forward or reverse) over a valid/ready handshake
module des_key_schedule
  import des_pkg::*;
#(
  parameter bit PARITY_CHECK = 0,
  parameter bit STALL_HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W:1]    key,
  input  logic              decrypt,
  input  logic              subkey_ready,
  output logic              subkey_valid,
  output logic [SUBKEY_W:1] subkey,
  output logic [4:0]        round_idx,
  output logic              busy,
  output logic              done,
  output logic              parity_err
);
  state_t state;
  logic [HALF_W-1:0] c, d;
  logic dec, hs, perr;
  logic [3:0] cnt;
  int amt;
  logic [2*HALF_W-1:0] cd_next;
  logic [SUBKEY_W:1] sk_next;
  // next C/D: first rotation in LOAD, then one step per handshake; the last step restores C0/D0
  always_comb begin
    hs = state == EMIT && subkey_valid && subkey_ready;
    perr = 1'b0;
    for (int b = 0; b < 8; b++) perr |= ~^key[8*b+1 +: 8];
    amt = state == LOAD ? (dec ? 0 : SHIFT[0]) :
          !hs ? 0 :
          dec ? HALF_W - SHIFT[~cnt] :
          cnt == 4'd15 ? 0 : SHIFT[cnt + 4'd1];
    cd_next = {rotl(c, amt), rotl(d, amt)};
  end
  des_pc2 u_pc2 (.cd(cd_next), .subkey(sk_next));
  // schedule FSM with registered outputs; done is raised leaving FINISH and blocks start that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c <= '0;
      d <= '0;
      dec <= 1'b0;
      cnt <= '0;
      subkey_valid <= 1'b0;
      subkey <= '0;
      round_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !done) begin
            {c, d} <= pc1(key);
            dec <= decrypt;
            parity_err <= PARITY_CHECK && perr;
            busy <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          {c, d} <= cd_next;
          subkey <= sk_next;
          round_idx <= dec ? 5'd16 : 5'd1;
          cnt <= '0;
          state <= EMIT;
        end
        EMIT: begin
          {c, d} <= cd_next;
          if (hs || !STALL_HOLD) subkey <= sk_next;
          if (!subkey_valid) subkey_valid <= 1'b1;
          else if (hs) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              subkey_valid <= 1'b0;
              state <= FINISH;
            end else round_idx <= dec ? round_idx - 5'd1 : round_idx + 5'd1;
          end
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: randomized scoreboard bench against a bit-array DES key-schedule model
`timescale 1ns/1ps
module tb_des_key_schedule;
  logic clk = 0, rst_n = 0, start = 0, decrypt = 0, subkey_ready = 0;
  logic [64:1] key = '0;
  logic subkey_valid, busy, done, parity_err;
  logic [48:1] subkey;
  logic [4:0] round_idx;

  des_key_schedule #(.PARITY_CHECK(1), .STALL_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .decrypt(decrypt),
    .subkey_ready(subkey_ready), .subkey_valid(subkey_valid), .subkey(subkey),
    .round_idx(round_idx), .busy(busy), .done(done), .parity_err(parity_err));

  always #5 clk = ~clk;

  localparam logic [63:0] KNOWN = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1 = 48'h1B02EFFC7072;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;
  int PC1 [0:55] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                     10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                     14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int PC2 [0:47] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                     23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                     41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int SHIFT [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {logic [47:0] sk; logic [4:0] idx;} exp_t;
  exp_t q[$];
  logic [47:0] ks [1:16];
  logic [47:0] first_sk, last_sk;
  logic [4:0] first_idx, last_idx;
  int checks = 0, errors = 0, done_cnt = 0, hs_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // textbook schedule: PC-1 into bit arrays, cumulative left rotations, PC-2 per round
  task automatic model(input logic [63:0] k);
    bit kb [1:64];
    bit c [0:27];
    bit d [0:27];
    bit t;
    int p;
    for (int n = 1; n <= 64; n++) kb[n] = k[64-n];
    for (int i = 0; i < 28; i++) begin
      c[i] = kb[PC1[i]];
      d[i] = kb[PC1[28+i]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFT[r]; s++) begin
        t = c[0];
        for (int i = 0; i < 27; i++) c[i] = c[i+1];
        c[27] = t;
        t = d[0];
        for (int i = 0; i < 27; i++) d[i] = d[i+1];
        d[27] = t;
      end
      for (int j = 0; j < 48; j++) begin
        p = PC2[j];
        ks[r+1][47-j] = p <= 28 ? c[p-1] : d[p-29];
      end
    end
  endtask

  function automatic bit par_bad(input logic [63:0] k);
    for (int b = 0; b < 8; b++) if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_exp(input logic [63:0] k, input bit dec);
    int idx;
    model(k);
    for (int r = 1; r <= 16; r++) begin
      idx = dec ? 17 - r : r;
      q.push_back('{sk: ks[idx], idx: 5'(idx)});
    end
  endtask

  // monitor: every valid cycle must present the scoreboard head; a handshake retires it
  always @(negedge clk) begin
    if (rst_n) begin
      if (subkey_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_subkey: got %h idx %0d expected none", subkey, round_idx);
        end else begin
          chk("subkey", 64'(subkey), 64'(q[0].sk));
          chk("round_idx", 64'(round_idx), 64'(q[0].idx));
          if (subkey_ready) begin
            if (hs_cnt == 0) begin
              first_sk = subkey;
              first_idx = round_idx;
            end
            last_sk = subkey;
            last_idx = round_idx;
            hs_cnt++;
            void'(q.pop_front());
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_with_queue_empty", 64'(q.size()), 64'd0);
      end
    end
  end

  function automatic logic rdy(input int mode, input int n);
    return mode == 0 ? 1'b1 : mode == 1 ? logic'(n % 4 == 1) : logic'($urandom_range(0, 1));
  endfunction

  // called one step after the start edge; n counts rising edges since that edge
  task automatic wait_done(input int mode, output int n, output int fv, output bit ok);
    n = 0;
    fv = -1;
    ok = 0;
    forever begin
      if (subkey_valid && fv < 0) fv = n;
      if (done) begin
        ok = 1;
        return;
      end
      if (n >= 400) return;
      subkey_ready = rdy(mode, n);
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic tail(input int mode, input int d0, input int n, input int fv, input bit ok);
    chk("done_seen", 64'(ok), 64'd1);
    if (mode == 0) begin
      chk("first_valid_latency", 64'(fv), 64'd2);
      chk("done_latency", 64'(n), 64'd19);
    end
    chk("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    #1;
    chk("handshakes", 64'(hs_cnt), 64'd16);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    subkey_ready = $urandom_range(0, 1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic run(input logic [63:0] k, input bit dec, input int mode, input bit hold,
                     input bit known, input logic [47:0] ef, input logic [4:0] efi,
                     input logic [47:0] el, input logic [4:0] eli);
    int n, fv, d0;
    bit ok;
    hs_cnt = 0;
    d0 = done_cnt;
    push_exp(k, dec);
    @(posedge clk);
    #1;
    key = k;
    decrypt = dec;
    start = 1;
    @(posedge clk);
    #1;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("parity_err", 64'(parity_err), 64'(par_bad(k)));
    if (!hold) begin
      start = 0;
      key = {$urandom, $urandom};
      decrypt = ~dec;
    end
    wait_done(mode, n, fv, ok);
    if (known) begin
      chk("first_subkey", 64'(first_sk), 64'(ef));
      chk("first_round_idx", 64'(first_idx), 64'(efi));
      chk("last_subkey", 64'(last_sk), 64'(el));
      chk("last_round_idx", 64'(last_idx), 64'(eli));
    end
    tail(mode, d0, n, fv, ok);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, fv, d0;
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    chk("rst_round_idx", 64'(round_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_parity", 64'(parity_err), 64'd0);
    rst_n = 1;
    subkey_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start_busy", 64'(busy), 64'd0);
    chk("idle_ready_no_valid", 64'(subkey_valid), 64'd0);
    run(KNOWN, 0, 0, 0, 1, K1, 5'd1, K16, 5'd16);
    run(KNOWN, 1, 0, 0, 1, K16, 5'd16, K1, 5'd1);
    run(KNOWN, 0, 1, 0, 1, K1, 5'd1, K16, 5'd16);
    run(64'h0, 0, 0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 8; i++)
      run({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 0, '0, '0, '0, '0);
    // start held high: ignored while done is up, accepted on the next idle cycle
    run(KNOWN, 0, 0, 1, 1, K1, 5'd1, K16, 5'd16);
    hs_cnt = 0;
    d0 = done_cnt;
    push_exp(KNOWN, 0);
    @(posedge clk);
    #1;
    chk("held_start_second_accept", 64'(busy), 64'd1);
    start = 0;
    wait_done(0, n, fv, ok);
    tail(0, d0, n, fv, ok);
    // reset during round 7 aborts the schedule
    hs_cnt = 0;
    push_exp(KNOWN, 0);
    @(posedge clk);
    #1;
    key = KNOWN;
    decrypt = 0;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    subkey_ready = 1;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = subkey_valid && round_idx == 5'd7;
    end
    chk("reached_round7", 64'(ok), 64'd1);
    #2;
    rst_n = 0;
    #1;
    chk("abort_valid", 64'(subkey_valid), 64'd0);
    chk("abort_subkey", 64'(subkey), 64'd0);
    chk("abort_round_idx", 64'(round_idx), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_parity", 64'(parity_err), 64'd0);
    q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    run(KNOWN, 0, 0, 0, 1, K1, 5'd1, K16, 5'd16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have parameter PARITY_CHECK, default 0; when 1, the block checks each key byte for odd parity.
REQ-002 SHALL have parameter STALL_HOLD, default 1; when 1, subkey and round_idx hold stable while subkey_valid=1 and subkey_ready=0.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to begin a schedule; sampled only in IDLE.
REQ-006 SHALL have port key, input, [64:1]: DES key; bit 1 is the MSB and bits 8,16,...,64 are parity bits.
REQ-007 SHALL have port decrypt, input, 1 bit: 0 = emit K1..K16; 1 = emit K16..K1; sampled with start.
REQ-008 SHALL have port subkey_ready, input, 1 bit: downstream round stage accepts the current subkey.
REQ-009 SHALL have port subkey_valid, output, 1 bit: subkey is valid.
REQ-010 SHALL have port subkey, output, [48:1]: current round key.
REQ-011 SHALL have port round_idx, output, [4:0]: DES round number 1..16 of the current subkey.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the 16th subkey handshake.
REQ-014 SHALL have port parity_err, output, 1 bit: key parity failure, latched at start; constant 0 when PARITY_CHECK=0.

Function
REQ-015 SHALL implement an FSM with states IDLE, LOAD, EMIT and FINISH.
REQ-016 In IDLE with start=1, SHALL latch PC-1(key) into the 28-bit C and D registers, latch decrypt, and go to LOAD.
REQ-017 In IDLE, start=0 SHALL leave every output unchanged at its idle value.
REQ-018 In LOAD, SHALL form the first subkey, register it, assert subkey_valid on the next edge, and go to EMIT.
- First valid is therefore 2 cycles after the start edge.
REQ-019 Encrypt mode: round i SHALL use C and D after cumulative left rotation by SHIFT[1..i], then PC-2.
- SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-020 Decrypt mode: the first subkey SHALL be PC-2(C0,D0), which equals K16.
- Each following subkey SHALL rotate right by SHIFT[16], SHIFT[15], ..., SHIFT[2] in that order.
REQ-021 In EMIT, a handshake SHALL occur on a cycle with subkey_valid=1 and subkey_ready=1; each handshake advances to the next subkey with no bubble.
REQ-022 round_idx SHALL count 1..16 in encrypt mode and 16..1 in decrypt mode.
REQ-023 On the 16th handshake, SHALL deassert subkey_valid on the next edge and go to FINISH.
REQ-024 In FINISH, SHALL assert done for exactly one cycle and return to IDLE.
REQ-025 start SHALL be ignored while busy=1; key and decrypt may change freely after the start edge.
REQ-026 Arbitrarily long subkey_ready=0 stalls SHALL neither lose nor duplicate a subkey.
REQ-027 subkey_ready=1 outside EMIT SHALL have no effect.
REQ-028 start=1 in the cycle done=1 SHALL be ignored; it is accepted only from IDLE on the following cycle.
REQ-029 Each C/D rotation SHALL be modulo 28 bits; after 16 rounds C and D SHALL return to C0,D0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE and clear all of the following to 0: C/D registers, counter, subkey_valid, subkey, round_idx, busy, done and parity_err.
REQ-031 Reset asserted mid-EMIT SHALL abort the schedule; no further subkeys SHALL be emitted and no done pulse SHALL occur.
REQ-032 After rst_n deasserts, the first accepted start SHALL behave identically to a start after a normal completion.

Structure
REQ-033 The shared package des_pkg SHALL hold the PC-1 table, the PC-2 table, the SHIFT schedule, the FSM state type, and the width constants KEY_W=64, HALF_W=28 and SUBKEY_W=48.
REQ-034 The PC-2 permutation SHALL be a combinational sub-module named des_pc2, reusable by the round stage.
REQ-035 The block SHALL contain no S-box or data-path logic; it feeds subkeys only to the downstream DES round core.

Verification
REQ-036 key=64'h133457799BBCDFF1, decrypt=0, ready held 1 -> first subkey=48'h1B02EFFC7072 with round_idx=1; 16th subkey=48'hCB3D8B0E17F5; done 19 cycles after the start edge.
REQ-037 Same key, decrypt=1 -> first subkey=48'hCB3D8B0E17F5 with round_idx=16; last subkey=48'h1B02EFFC7072 with round_idx=1.
REQ-038 Encrypt run with ready low 3 cycles at every round -> subkey holds stable during each stall; exactly 16 handshakes; same 16 values as the no-stall run.
REQ-039 PARITY_CHECK=1: key=64'h0 -> parity_err=1; key=64'h133457799BBCDFF1 -> parity_err=0.
REQ-040 rst_n pulsed low during round 7 -> all outputs 0 immediately with no done pulse; a new start reproduces the REQ-036 sequence.
REQ-041 start held high for a whole run -> exactly one schedule; a second schedule begins only from IDLE, the cycle after done.
